uart_tx: RTL and testbench

//   Serial UART transmitter. It is the upstream stage of uart_rx and drives uart_rx's rx input on the shared clk_50M.

---
 rtl/uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-queued serial UART transmitter, 8N1 framing, data MSB-first.
// Bytes pushed through a valid/ready handshake land in a small FIFO and are
// sent back to back as 10-bit frames (start 0, d7..d0, stop 1).
// Ports:
//   clk_50M   system clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   tx_data   byte to send, taken when tx_valid && tx_ready
//   tx_valid  producer has a byte on tx_data
//   tx_ready  FIFO not full (decoded from registered count)
//   tx        registered serial line, idles high
//   tx_busy   frame on the line or bytes still queued
//   tx_done   one-cycle pulse as a frame's stop bit completes
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state, state_nx;
   logic [TMR_W-1:0]   timer, timer_nx;
   logic [2:0]         bit_idx, bit_idx_nx;
   logic [7:0]         shift_reg, shift_nx;
   logic               tx_nx;
   logic               done_nx;
   logic               pop;
   logic               push;
   logic               bit_end;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [7:0]         head;

   // Handshake and status decode from registered FIFO/FSM state
   assign tx_ready = (count != CNT_W'(FIFO_DEPTH));
   assign tx_busy  = (state != IDLE) || (count != '0);
   assign push     = tx_valid && tx_ready;
   assign head     = mem[rd_ptr];
   assign bit_end  = (timer == TMR_W'(CLKS_PER_BIT - 1));

   // FIFO storage; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk_50M) begin
      if (rst_n && push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         bit_idx   <= bit_idx_nx;
         shift_reg <= shift_nx;
         tx        <= tx_nx;
         tx_done   <= done_nx;
      end
   end

   // Next-state logic; shift_reg shifts left so bit 7 is always the next data bit
   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      bit_idx_nx = bit_idx;
      shift_nx   = shift_reg;
      tx_nx      = tx;
      done_nx    = 1'b0;
      pop        = 1'b0;

      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (count != '0) begin
               pop      = 1'b1;
               shift_nx = head;
               tx_nx    = 1'b0;
               timer_nx = '0;
               state_nx = START;
            end
         end

         START: begin
            if (bit_end) begin
               tx_nx      = shift_reg[7];
               shift_nx   = {shift_reg[6:0], 1'b0};
               bit_idx_nx = '0;
               timer_nx   = '0;
               state_nx   = DATA;
            end else begin
               timer_nx = timer + TMR_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               timer_nx = '0;
               if (bit_idx != 3'd7) begin
                  bit_idx_nx = bit_idx + 3'd1;
                  tx_nx      = shift_reg[7];
                  shift_nx   = {shift_reg[6:0], 1'b0};
               end else begin
                  tx_nx    = 1'b1;
                  state_nx = STOP;
               end
            end else begin
               timer_nx = timer + TMR_W'(1);
            end
         end

         STOP: begin
            if (bit_end) begin
               done_nx  = 1'b1;
               timer_nx = '0;
               // Chain straight into the next start bit when bytes are waiting
               if (count != '0) begin
                  pop      = 1'b1;
                  shift_nx = head;
                  tx_nx    = 1'b0;
                  state_nx = START;
               end else begin
                  tx_nx    = 1'b1;
                  state_nx = IDLE;
               end
            end else begin
               timer_nx = timer + TMR_W'(1);
            end
         end

         default: begin
            tx_nx    = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a line monitor decodes every frame on tx into queues
// (byte, start cycle, framing ok) and logs tx_done cycles; each scenario task
// compares those against timings derived from frame arithmetic.
module tb_uart_tx;

   localparam int CPB   = 434;
   localparam int FRAME = 10 * CPB;
   localparam int DEPTH = 4;

   logic       clk_50M = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int vec = 0;
   int err = 0;
   int cyc = 0;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   always #5 clk_50M = ~clk_50M;
   always @(posedge clk_50M) cyc <= cyc + 1;

   // Line monitor state
   logic [7:0] rx_q[$];
   int         st_q[$];
   bit         ok_q[$];
   int         done_q[$];
   int         last_busy = -1;
   bit         in_frame = 0;
   int         k, bn, start_cyc;
   bit         shape_ok;
   logic       bit_val;
   logic [7:0] data_sh;

   always @(negedge clk_50M) begin
      if (rst_n !== 1'b1) begin
         in_frame = 0;
      end else begin
         if (!in_frame && tx === 1'b0) begin
            in_frame  = 1;
            k         = 0;
            start_cyc = cyc;
            shape_ok  = 1;
            data_sh   = 8'h00;
         end
         if (in_frame) begin
            if (k % CPB == 0) begin
               bit_val = tx;
               bn = k / CPB;
               if (bn == 0 && tx !== 1'b0) shape_ok = 0;
               if (bn >= 1 && bn <= 8) data_sh = {data_sh[6:0], tx};
               if (bn == 9 && tx !== 1'b1) shape_ok = 0;
            end else if (tx !== bit_val) begin
               shape_ok = 0;
            end
            if (k == FRAME - 1) begin
               rx_q.push_back(data_sh);
               st_q.push_back(start_cyc);
               ok_q.push_back(shape_ok);
               in_frame = 0;
            end
            k++;
         end
      end
      if (tx_done === 1'b1) done_q.push_back(cyc);
      if (tx_busy === 1'b1) last_busy = cyc;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic clear_logs();
      rx_q.delete();
      st_q.delete();
      ok_q.delete();
      done_q.delete();
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_50M);
         #1;
      end
   endtask

   task automatic wait_until(input int target);
      for (int i = 0; i < 200000 && cyc < target; i++) begin
         @(posedge clk_50M);
         #1;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 8 * FRAME; i++) begin
         if (tx_busy === 1'b0) begin
            ok = 1;
            break;
         end
         step(1);
      end
      step(2);
   endtask

   // Offer a byte until accepted; returns the accept edge, or -1 on timeout
   task automatic send_byte(input logic [7:0] b, output int acc_edge);
      logic acc;
      tx_data  = b;
      tx_valid = 1'b1;
      acc_edge = -1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         acc = tx_ready;
         @(posedge clk_50M);
         #1;
         if (acc === 1'b1) begin
            acc_edge = cyc;
            break;
         end
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      for (int i = 0; i < 5; i++) begin
         step(1);
         tx_data = 8'($urandom);
         vec++;
         if ({tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            err++;
            $display("FAIL reset_hold[%0d]: tx/ready/busy/done=%b required 1100", i,
                     {tx, tx_ready, tx_busy, tx_done});
         end
      end
      tx_valid = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         vec++;
         if ({tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            err++;
            $display("FAIL reset_release[%0d]: tx/ready/busy/done=%b required 1100", i,
                     {tx, tx_ready, tx_busy, tx_done});
         end
      end
   endtask

   task automatic test_single();
      int n;
      bit ok;
      clear_logs();
      send_byte(8'hA5, n);
      wait_idle(ok);
      vec++;
      if (!ok || rx_q.size() != 1 || done_q.size() != 1) begin
         err++;
         $display("FAIL single_count: idle=%0b frames=%0d dones=%0d required 1 1 1", ok,
                  rx_q.size(), done_q.size());
      end else begin
         vec++;
         if (rx_q[0] !== 8'hA5 || !ok_q[0]) begin
            err++;
            $display("FAIL single_data: byte=%h framing_ok=%0b required a5 1", rx_q[0], ok_q[0]);
         end
         vec++;
         if (st_q[0] != n + 1) begin
            err++;
            $display("FAIL single_start: start=%0d required %0d", st_q[0], n + 1);
         end
         vec++;
         if (done_q[0] != n + 1 + FRAME) begin
            err++;
            $display("FAIL single_done: done=%0d required %0d", done_q[0], n + 1 + FRAME);
         end
      end
   endtask

   task automatic test_loopback();
      int n, complete, diff;
      logic [7:0] msg;
      bit ok;
      clear_logs();
      send_byte(8'h3C, n);
      // Receiver model: find start edge, sample mid-bit, complete at stop end
      ok  = 0;
      msg = 8'h00;
      complete = -1;
      for (int i = 0; i < 2 * CPB; i++) begin
         @(negedge clk_50M);
         if (tx === 1'b0) begin
            ok = 1;
            break;
         end
      end
      if (ok) begin
         repeat (CPB / 2) @(negedge clk_50M);
         if (tx !== 1'b0) ok = 0;
         for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk_50M);
            msg = {msg[6:0], tx};
         end
         repeat (CPB) @(negedge clk_50M);
         if (tx !== 1'b1) ok = 0;
         repeat (CPB - CPB / 2) @(negedge clk_50M);
         complete = cyc;
      end
      step(5);
      vec++;
      if (!ok || msg !== 8'h3C) begin
         err++;
         $display("FAIL loopback_msg: rx_msg=%h framing_ok=%0b required 3c 1", msg, ok);
      end
      vec++;
      if (done_q.size() != 1) begin
         err++;
         $display("FAIL loopback_done_count: dones=%0d required 1", done_q.size());
      end else begin
         diff = complete - done_q[0];
         vec++;
         if (diff < 0 || diff > CPB) begin
            err++;
            $display("FAIL loopback_align: rx_complete-tx_done=%0d required 0..%0d", diff, CPB);
         end
      end
      wait_idle(ok);
   endtask

   task automatic test_burst();
      int acc[6];
      bit ok;
      clear_logs();
      for (int i = 1; i <= 5; i++) send_byte(8'(i), acc[i]);
      for (int i = 2; i <= 5; i++) begin
         vec++;
         if (acc[i] != acc[1] + i - 1) begin
            err++;
            $display("FAIL burst_accept[%0d]: edge=%0d required %0d", i, acc[i], acc[1] + i - 1);
         end
      end
      // First byte left for the line at once, so four remain queued: full
      vec++;
      if (tx_ready !== 1'b0) begin
         err++;
         $display("FAIL burst_full: tx_ready=%b required 0", tx_ready);
      end
      wait_until(acc[1] + FRAME);
      vec++;
      if (tx_ready !== 1'b0) begin
         err++;
         $display("FAIL burst_full_hold: tx_ready=%b required 0", tx_ready);
      end
      step(1);
      vec++;
      if (tx_ready !== 1'b1) begin
         err++;
         $display("FAIL burst_slot_freed: tx_ready=%b required 1", tx_ready);
      end
      wait_idle(ok);
      vec++;
      if (rx_q.size() != 5 || done_q.size() != 5) begin
         err++;
         $display("FAIL burst_count: frames=%0d dones=%0d required 5 5", rx_q.size(), done_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vec++;
            if (rx_q[i] !== 8'(i + 1) || !ok_q[i] || st_q[i] != acc[1] + 1 + i * FRAME
                || done_q[i] != acc[1] + 1 + (i + 1) * FRAME) begin
               err++;
               $display("FAIL burst_frame[%0d]: byte=%h ok=%0b start=%0d done=%0d required %h 1 %0d %0d",
                        i, rx_q[i], ok_q[i], st_q[i], done_q[i], 8'(i + 1),
                        acc[1] + 1 + i * FRAME, acc[1] + 1 + (i + 1) * FRAME);
            end
         end
         vec++;
         if (last_busy != done_q[4] - 1) begin
            err++;
            $display("FAIL burst_busy_end: last busy cycle=%0d required %0d", last_busy, done_q[4] - 1);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n, n1, n2, m;
      bit ok;
      clear_logs();
      send_byte(8'hFF, n);
      send_byte(8'($urandom), n1);
      send_byte(8'($urandom), n2);
      m = n + 1 + 4 * CPB + CPB / 2;
      wait_until(m - 1);
      rst_n = 1'b0;
      step(1);
      vec++;
      if ({tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
         err++;
         $display("FAIL reset_mid_abort: tx/ready/busy/done=%b required 1100",
                  {tx, tx_ready, tx_busy, tx_done});
      end
      step(1);
      rst_n = 1'b1;
      clear_logs();
      step(FRAME + CPB);
      vec++;
      if (rx_q.size() != 0 || done_q.size() != 0 || tx !== 1'b1 || tx_busy !== 1'b0) begin
         err++;
         $display("FAIL reset_mid_flush: frames=%0d dones=%0d tx=%b busy=%b required 0 0 1 0",
                  rx_q.size(), done_q.size(), tx, tx_busy);
      end
      send_byte(8'h81, n);
      wait_idle(ok);
      vec++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h81 || !ok_q[0] || st_q[0] != n + 1
          || done_q.size() != 1 || done_q[0] != n + 1 + FRAME) begin
         err++;
         $display("FAIL reset_mid_next: frames=%0d byte=%h dones=%0d required 1 81 1",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, done_q.size());
      end
   endtask

   task automatic test_push_on_pop();
      logic [7:0] exp[5];
      int acc[5];
      bit ok;
      clear_logs();
      for (int i = 0; i < 5; i++) exp[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) send_byte(exp[i], acc[i]);
      // Three queued; offer the fifth so it lands on the edge STOP pops
      wait_until(acc[0] + FRAME);
      send_byte(exp[4], acc[4]);
      vec++;
      if (acc[4] != acc[0] + 1 + FRAME) begin
         err++;
         $display("FAIL pop_push_edge: accept=%0d required %0d", acc[4], acc[0] + 1 + FRAME);
      end
      vec++;
      if (tx_ready !== 1'b1) begin
         err++;
         $display("FAIL pop_push_count: tx_ready=%b required 1", tx_ready);
      end
      wait_idle(ok);
      vec++;
      if (rx_q.size() != 5) begin
         err++;
         $display("FAIL pop_push_frames: frames=%0d required 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vec++;
            if (rx_q[i] !== exp[i] || !ok_q[i] || st_q[i] != acc[0] + 1 + i * FRAME) begin
               err++;
               $display("FAIL pop_push_order[%0d]: byte=%h ok=%0b start=%0d required %h 1 %0d",
                        i, rx_q[i], ok_q[i], st_q[i], exp[i], acc[0] + 1 + i * FRAME);
            end
         end
      end
   endtask

   task automatic test_random_gap();
      logic [7:0] b0, b1;
      int a0, a1, s1;
      bit ok;
      clear_logs();
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      send_byte(b0, a0);
      step($urandom_range(0, 12 * CPB));
      send_byte(b1, a1);
      wait_idle(ok);
      // Second frame starts when accepted into an idle line, or right at first stop end
      s1 = (a1 + 1 > a0 + 1 + FRAME) ? a1 + 1 : a0 + 1 + FRAME;
      vec++;
      if (rx_q.size() != 2 || done_q.size() != 2) begin
         err++;
         $display("FAIL gap_count: frames=%0d dones=%0d required 2 2", rx_q.size(), done_q.size());
      end else begin
         vec++;
         if (rx_q[0] !== b0 || rx_q[1] !== b1 || !ok_q[0] || !ok_q[1]) begin
            err++;
            $display("FAIL gap_data: bytes=%h %h required %h %h", rx_q[0], rx_q[1], b0, b1);
         end
         vec++;
         if (st_q[0] != a0 + 1 || st_q[1] != s1 || done_q[1] != s1 + FRAME) begin
            err++;
            $display("FAIL gap_timing: starts=%0d %0d done=%0d required %0d %0d %0d",
                     st_q[0], st_q[1], done_q[1], a0 + 1, s1, s1 + FRAME);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      @(posedge clk_50M);
      #1;
      test_reset();
      test_single();
      test_loopback();
      test_burst();
      test_reset_mid();
      test_push_on_pop();
      test_random_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
